// File: rtl/seg_scan_disp.sv
// rtl/seg_scan_disp.sv - multiplexed 7-segment driver with sequential double-dabble BCD conversion.
// Optional blanking blink for game-over flashing is enabled with `define SEG_BLINK_EN.
module seg_scan_disp #(
    parameter int DIGITS   = 6,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_DIV = 12_500_000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  value,
    input  logic              load,
`ifdef SEG_BLINK_EN
    input  logic              blink,
`endif
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        dig
);

    function automatic int dec_digits(input int w);
        longint unsigned m;
        int n;
        m = (64'd1 << w) - 64'd1;
        n = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int d);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < d; i++) r = r * 64'd10;
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Shift register is wide enough for the full binary range and for every displayed digit.
    localparam int NB_BIN = dec_digits(BIN_W);
    localparam int NB     = (NB_BIN > DIGITS) ? NB_BIN : DIGITS;
    localparam longint unsigned LIMIT = pow10(DIGITS) - 64'd1;
    localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [BIN_W-1:0]    cap;
    logic [BIN_W-1:0]    bin_sh;
    logic [4*NB-1:0]     bcd;
    logic [4*NB-1:0]     bcd_adj;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] disp;
    logic                cap_ovf;

    logic [SW-1:0]       scan_cnt;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       slot;
    logic [DIGITS-1:0]   blank;
    logic                nz;
    logic [DIGITS-1:0]   sel_next;
    logic [7:0]          dig_next;
    logic                dark;

    assign cap_ovf = ({{(64-BIN_W){1'b0}}, cap} > LIMIT);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ovf    <= 1'b0;
            cap    <= '0;
            bin_sh <= '0;
            bcd    <= '0;
            cnt    <= '0;
            disp   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        cap    <= value;
                        bin_sh <= value;
                        bcd    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd    <= {bcd_adj[4*NB-2:0], bin_sh[BIN_W-1]};
                    bin_sh <= bin_sh << 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(BIN_W - 1)) state <= DONE;
                end
                DONE: begin
                    // Whole display updated in one edge so a scan never mixes old and new digits.
                    disp  <= cap_ovf ? {DIGITS{4'h9}} : bcd[4*DIGITS-1:0];
                    ovf   <= cap_ovf;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // A digit is blanked when it and everything above it is zero; units always shows.
    always_comb begin
        nz    = 1'b0;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz       = nz | (disp[4*i +: 4] != 4'd0);
            blank[i] = !nz && (i != 0);
        end
    end

    assign slot = IW'(DIGITS - 1) - idx;

    always_comb begin
        sel_next       = '1;
        sel_next[slot] = 1'b0;
        dig_next       = blank[idx] ? 8'hFF : seg7(disp[4*idx +: 4]);
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign dark = blink & ~phase;
`else
    assign dark = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '1;
            dig <= 8'hFF;
        end else begin
            sel <= dark ? '1 : sel_next;
            dig <= dark ? 8'hFF : dig_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_disp.sv
// tb/tb_seg_scan_disp.sv - self-checking bench for seg_scan_disp with a decimal display model.
module tb_seg_scan_disp;
    localparam int DIGITS   = 6;
    localparam int BIN_W    = 14;
    localparam int SCAN_DIV = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [BIN_W-1:0] value = '0;
    logic             load = 1'b0;
    logic             load3 = 1'b0;
    logic             busy, ovf, busy3, ovf3;
    logic [5:0]       sel;
    logic [2:0]       sel3;
    logic [7:0]       dig, dig3;

    always #5 clk = ~clk;

    seg_scan_disp #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) u6 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
`ifdef SEG_BLINK_EN
        .blink(1'b0),
`endif
        .busy(busy), .ovf(ovf), .sel(sel), .dig(dig)
    );

    seg_scan_disp #(.DIGITS(3), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) u3 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load3),
`ifdef SEG_BLINK_EN
        .blink(1'b0),
`endif
        .busy(busy3), .ovf(ovf3), .sel(sel3), .dig(dig3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int p10(input int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_dig_f(input int v, input bit ov, input int i);
        if (ov) return 8'h90;
        if (i > 0 && v < p10(i)) return 8'hFF;
        return seg_of((v / p10(i)) % 10);
    endfunction

    // Model: decimal value on the display plus elapsed clock count since reset release.
    int         k;
    int         m_val;
    bit         m_busy;
    bit         m_ovf;
    int         m_done_at;
    int         m_pend;
    int         m_slot;
    logic [5:0] e_sel = 6'h3F;
    logic [7:0] e_dig = 8'hFF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; m_val = 0; m_busy = 0; m_ovf = 0; m_done_at = 0; m_pend = 0;
            e_sel = 6'h3F; e_dig = 8'hFF;
        end else begin
            m_slot = (k / SCAN_DIV) % DIGITS;
            e_sel = 6'h3F;
            e_sel[DIGITS-1-m_slot] = 1'b0;
            e_dig = exp_dig_f(m_val, m_ovf, m_slot);
            k++;
            if (m_busy && k == m_done_at) begin
                m_busy = 0;
                m_ovf  = (m_pend > p10(DIGITS) - 1);
                m_val  = m_pend;
            end else if (!m_busy && load) begin
                m_busy    = 1;
                m_done_at = k + BIN_W + 1;
                m_pend    = int'(value);
            end
        end
    end

    always @(negedge clk) begin
        check("sel", sel, e_sel);
        check("dig", dig, e_dig);
        check("busy", busy, m_busy);
        check("ovf", ovf, m_ovf);
        if (rst_n && k > 0) check("one_low", $countones(~sel), 1);
    end

    logic [7:0] slot_dig [6];
    logic [7:0] slot3 [3];
    logic [5:0] order [6];

    task automatic capture6();
        for (int i = 0; i < 6; i++) slot_dig[i] = 8'h00;
        for (int j = 0; j < SCAN_DIV * 6; j++) begin
            @(negedge clk);
            for (int b = 0; b < 6; b++) if (!sel[b]) slot_dig[5-b] = dig;
        end
    endtask

    task automatic check_slots(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3,
                               input logic [7:0] e4, input logic [7:0] e5);
        capture6();
        check({tag, "_d0"}, slot_dig[0], e0);
        check({tag, "_d1"}, slot_dig[1], e1);
        check({tag, "_d2"}, slot_dig[2], e2);
        check({tag, "_d3"}, slot_dig[3], e3);
        check({tag, "_d4"}, slot_dig[4], e4);
        check({tag, "_d5"}, slot_dig[5], e5);
    endtask

    task automatic do_load(input int v);
        @(negedge clk);
        value = BIN_W'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        int n;
        order[0] = 6'b011111; order[1] = 6'b101111; order[2] = 6'b110111;
        order[3] = 6'b111011; order[4] = 6'b111101; order[5] = 6'b111110;

        repeat (3) @(negedge clk);
        check("rst_sel", sel, 6'h3F);
        check("rst_dig", dig, 8'hFF);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;

        for (int j = 0; j < SCAN_DIV * 6; j++) begin
            @(negedge clk);
            check("scan_order", sel, order[j / SCAN_DIV]);
            check("idle_dig", dig, (j < SCAN_DIV) ? 8'hC0 : 8'hFF);
        end

        do_load(1234);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, 15);
        repeat (2) @(negedge clk);
        check_slots("v1234", 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF);

        do_load(0);
        repeat (20) @(negedge clk);
        check_slots("v0", 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        do_load(9999);
        repeat (20) @(negedge clk);
        check("ovf_9999", ovf, 1'b0);
        check_slots("v9999", 8'h90, 8'h90, 8'h90, 8'h90, 8'hFF, 8'hFF);

        // Second load three cycles after the first must be dropped.
        @(negedge clk);
        value = BIN_W'(5); load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        value = BIN_W'(7); load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (25) @(negedge clk);
        check_slots("v5", 8'h92, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        @(negedge clk);
        value = BIN_W'(1000); load3 = 1'b1;
        @(negedge clk);
        load3 = 1'b0;
        repeat (20) @(negedge clk);
        check("ovf3_1000", ovf3, 1'b1);
        check("busy3_done", busy3, 1'b0);
        for (int i = 0; i < 3; i++) slot3[i] = 8'h00;
        for (int j = 0; j < SCAN_DIV * 3; j++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) if (!sel3[b]) slot3[2-b] = dig3;
        end
        check("d3_u", slot3[0], 8'h90);
        check("d3_t", slot3[1], 8'h90);
        check("d3_h", slot3[2], 8'h90);

        do_load(4321);
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_sel", sel, 6'h3F);
        check("arst_dig", dig, 8'hFF);
        check("arst_busy", busy, 1'b0);
        check("arst_ovf3", ovf3, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_busy", busy, 1'b0);
        check_slots("post_rst", 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_disp.md
Name: seg_scan_disp

Overview:
- Parametrised, time-multiplexed 7-segment driver for the snake board; successor to the single-digit score display.
- Takes a binary value and converts it to BCD with a sequential double-dabble engine.
- Scans DIGITS digits with leading-zero blanking.
- Sits between the game score counter and the board's 6-digit common-anode display.

Parameters:
- DIGITS, 6, number of physical digits scanned (1..6).
- BIN_W, 14, width of the binary input value.
- SCAN_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  BIN_W  binary number to display
- load  in  1  one-cycle strobe; sample value and start conversion
- busy  out  1  conversion in progress
- ovf  out  1  latched value exceeds 10^DIGITS-1
- sel  out  DIGITS  digit select, active-low; sel[DIGITS-1] = units digit
- dig  out  8  segments {dp,g..a}, active-low

Behaviour:
- Reset/interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - sel = all ones (all digits off), dig = 8'hFF, busy = 0, ovf = 0.
  - Display BCD registers = 0, scan counter = 0, digit index = 0.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: load=1 captures value, clears BCD shift register, busy=1 next cycle, go SHIFT.
  - SHIFT: exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left by 1 bringing in the binary MSB.
  - DONE: one cycle. Copy result to the display registers atomically, busy=0, return to IDLE.
  - Load-to-display latency: BIN_W+2 cycles.
  - load while busy=1 is ignored (no restart, no queue).
- Overflow: if captured value > 10^DIGITS-1, DONE writes 9 to every digit and sets ovf=1. Otherwise ovf=0. ovf updates only in DONE.
- BCD shift register width: 4*ceil-to-cover BIN_W. Digits above DIGITS are used only for the overflow check.
- Scan counter:
  - Counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and the digit index advances.
  - Index order: 0 = units, up to DIGITS-1, then wraps to 0.
- sel: exactly one bit low at any time after reset. For index i, sel[DIGITS-1-i] = 0.
- dig encodes the display nibble at index i:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90.
  - Any other nibble: FF.
- Leading-zero blanking:
  - A digit at index i>0 is blank (dig=FF) when it and all higher digits are 0.
  - The units digit is never blanked; value 0 shows a single "0".
- sel and dig are registered and change together, one cycle after the index changes. No ghosting cycle with the new sel and old dig.
- The display keeps showing the previous value until DONE; no tearing mid-scan.
- Reset asserted mid-conversion or mid-scan: immediately return to reset values. No partial result is written.

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined:
  - Adds input port blink (1 bit) and parameter BLINK_DIV (default 12_500_000).
  - A free-running counter toggles a phase bit every BLINK_DIV cycles; phase resets to 1 (lit).
  - While blink=1 and phase=0: sel = all ones, dig = FF.
  - blink=0 forces a normal display regardless of phase.
  - Intended for game-over flashing.
- Not defined: no blink port or counter; display always lit. All other behaviour is identical.

Test Plan (bench uses SCAN_DIV=4, DIGITS=6, BIN_W=14):
- Reset then idle: sel=6'b111111, dig=FF during reset. After release, units slot shows sel=6'b011111 with dig=C0; the other five slots show dig=FF.
- load with value=1234:
  - busy high for 15 cycles after load; display unchanged until DONE.
  - Then the slots read units=99 ("4"), tens=B0, hundreds=A4, thousands=F9; ten-thousands and hundred-thousands = FF.
- Boundaries:
  - value=0 shows only units C0.
  - value=9999 shows four 90s and ovf=0.
  - With DIGITS=3, value=1000 shows 90 90 90 and ovf=1.
- Second load 3 cycles after the first (value=5 then 7): the second is ignored and the display shows 92.
- Scan timing: each sel pattern holds for exactly 4 cycles. Order is 011111, 101111, 110111, 111011, 111101, 111110, then wraps. Exactly one zero in sel every cycle.
- Reset asserted during SHIFT: outputs return to reset values within the same cycle. After release, the display shows 0, not a partial value.
